// File: rtl/idc_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : idc_counter_bank
// Description : Bank of independent address counters with per-channel limit,
//               wrap/saturate boundary handling and illegal-request flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module idc_counter_bank #(
    parameter int           NUM_CH   = 4,
    parameter int           WIDTH    = 8,
    parameter logic [3:0]   BASE_SEL = 4'b1001,
    parameter bit           SAT_MODE = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [2:0]                idc_op,
    input  logic [15:0]               instruction,
    output logic [NUM_CH*WIDTH-1:0]   count_out,
    output logic [NUM_CH-1:0]         at_zero,
    output logic [NUM_CH-1:0]         at_limit,
    output logic [NUM_CH-1:0]         wrap_pulse,
    output logic                      op_err
);

    localparam logic [2:0] c_op_hold   = 3'b000;
    localparam logic [2:0] c_op_inc    = 3'b001;
    localparam logic [2:0] c_op_dec    = 3'b010;
    localparam logic [2:0] c_op_clr    = 3'b011;
    localparam logic [2:0] c_op_load   = 3'b100;
    localparam logic [2:0] c_op_setlim = 3'b101;
    localparam logic [2:0] c_op_clrall = 3'b110;
    localparam logic [2:0] c_op_rsvd   = 3'b111;

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  w_imm;
    logic [NUM_CH-1:0] w_hit;
    logic              w_any_hit;
    logic              w_op_err;
    logic              r_op_err;
    logic              w_unused_instr;

    assign w_unused_instr = ^instruction[15:12];

    // Immediate is 8 bits wide; fit it to the counter width.
    generate
        if (WIDTH > 8) begin : g_imm_ext
            assign w_imm = {{(WIDTH-8){1'b0}}, instruction[7:0]};
        end else if (WIDTH == 8) begin : g_imm_same
            assign w_imm = instruction[7:0];
        end else begin : g_imm_trunc
            assign w_imm = instruction[WIDTH-1:0];
        end
    endgenerate

    assign w_any_hit = |w_hit;

    always_comb begin
        w_op_err = 1'b0;
        if (idc_op == c_op_rsvd) begin
            w_op_err = 1'b1;
        end else if ((idc_op != c_op_hold) && (idc_op != c_op_clrall) && !w_any_hit) begin
            w_op_err = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_op_err <= 1'b0;
        end else begin
            r_op_err <= w_op_err;
        end
    end

    assign op_err = r_op_err;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] r_limit;
            logic             r_wrap;
            logic [WIDTH-1:0] w_next_count;
            logic [WIDTH-1:0] w_next_limit;
            logic             w_next_wrap;

            // Compare at 32 bits so BASE_SEL+i never aliases into the 4-bit code space.
            assign w_hit[i] = (32'(instruction[11:8]) == (32'(BASE_SEL) + i));

            always_comb begin
                w_next_count = r_count;
                w_next_limit = r_limit;
                w_next_wrap  = 1'b0;
                if (w_hit[i]) begin
                    case (idc_op)
                        c_op_inc: begin
                            if (r_count == r_limit) begin
                                if (!SAT_MODE) begin
                                    w_next_count = '0;
                                    w_next_wrap  = 1'b1;
                                end
                            end else begin
                                w_next_count = r_count + c_one;
                            end
                        end
                        c_op_dec: begin
                            if (r_count == '0) begin
                                if (!SAT_MODE) begin
                                    w_next_count = r_limit;
                                    w_next_wrap  = 1'b1;
                                end
                            end else begin
                                w_next_count = r_count - c_one;
                            end
                        end
                        c_op_clr:    w_next_count = '0;
                        c_op_load:   w_next_count = w_imm;
                        c_op_setlim: w_next_limit = w_imm;
                        default: ;
                    endcase
                end
                if (idc_op == c_op_clrall) begin
                    w_next_count = '0;
                end
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_count <= '0;
                    r_limit <= '1;
                    r_wrap  <= 1'b0;
                end else begin
                    r_count <= w_next_count;
                    r_limit <= w_next_limit;
                    r_wrap  <= w_next_wrap;
                end
            end

            assign count_out[i*WIDTH +: WIDTH] = r_count;
            assign at_zero[i]                  = (r_count == '0);
            assign at_limit[i]                 = (r_count == r_limit);
            assign wrap_pulse[i]               = r_wrap;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_idc_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_idc_counter_bank
// Description : Self-checking bench; wrap-mode and saturate-mode instances
//               driven in parallel and compared to a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idc_counter_bank;

    logic        clock;
    logic        reset_n;
    logic [2:0]  idc_op;
    logic [15:0] instruction;

    logic [31:0] cnt_o  [2];
    logic [3:0]  zero_o [2];
    logic [3:0]  atl_o  [2];
    logic [3:0]  wrp_o  [2];
    logic        err_o  [2];

    // Index 0 = wrap mode, index 1 = saturate mode
    int          m_cnt  [2][4];
    int          m_lim  [2][4];
    logic [3:0]  m_wrap [2];
    logic        m_err  [2];

    int n_checks = 0;
    int n_fail   = 0;

    idc_counter_bank #(.NUM_CH(4), .WIDTH(8), .BASE_SEL(4'b1001), .SAT_MODE(1'b0)) u_wrap (
        .clock(clock), .reset_n(reset_n), .idc_op(idc_op), .instruction(instruction),
        .count_out(cnt_o[0]), .at_zero(zero_o[0]), .at_limit(atl_o[0]),
        .wrap_pulse(wrp_o[0]), .op_err(err_o[0])
    );

    idc_counter_bank #(.NUM_CH(4), .WIDTH(8), .BASE_SEL(4'b1001), .SAT_MODE(1'b1)) u_sat (
        .clock(clock), .reset_n(reset_n), .idc_op(idc_op), .instruction(instruction),
        .count_out(cnt_o[1]), .at_zero(zero_o[1]), .at_limit(atl_o[1]),
        .wrap_pulse(wrp_o[1]), .op_err(err_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [44:0] exp_vec(input int m);
        logic [31:0] c;
        logic [3:0]  z;
        logic [3:0]  l;
        for (int ch = 0; ch < 4; ch++) begin
            c[ch*8 +: 8] = 8'(m_cnt[m][ch]);
            z[ch]        = (m_cnt[m][ch] == 0);
            l[ch]        = (m_cnt[m][ch] == m_lim[m][ch]);
        end
        return {c, z, l, m_wrap[m], m_err[m]};
    endfunction

    function automatic logic [44:0] got_vec(input int m);
        return {cnt_o[m], zero_o[m], atl_o[m], wrp_o[m], err_o[m]};
    endfunction

    // Drive one operation for one clock and advance the reference model.
    task automatic apply(input logic [2:0] op, input logic [3:0] sel,
                         input logic [7:0] imm, input logic rn);
        int  ch;
        bit  hit;
        @(negedge clock);
        idc_op      = op;
        instruction = {4'($urandom_range(15)), sel, imm};
        reset_n     = rn;
        @(posedge clock);
        #1;
        ch  = int'(sel) - 9;
        hit = (ch >= 0) && (ch < 4);
        for (int m = 0; m < 2; m++) begin
            m_wrap[m] = 4'b0000;
            m_err[m]  = 1'b0;
            if (!rn) begin
                for (int k = 0; k < 4; k++) begin
                    m_cnt[m][k] = 0;
                    m_lim[m][k] = 255;
                end
            end else if (op == 3'd7 || (op >= 3'd1 && op <= 3'd5 && !hit)) begin
                m_err[m] = 1'b1;
            end else if (op == 3'd6) begin
                for (int k = 0; k < 4; k++) m_cnt[m][k] = 0;
            end else if (hit) begin
                case (op)
                    3'd1: begin
                        if (m_cnt[m][ch] == m_lim[m][ch]) begin
                            if (m == 0) begin
                                m_cnt[m][ch]  = 0;
                                m_wrap[m][ch] = 1'b1;
                            end
                        end else begin
                            m_cnt[m][ch] = (m_cnt[m][ch] + 1) % 256;
                        end
                    end
                    3'd2: begin
                        if (m_cnt[m][ch] == 0) begin
                            if (m == 0) begin
                                m_cnt[m][ch]  = m_lim[m][ch];
                                m_wrap[m][ch] = 1'b1;
                            end
                        end else begin
                            m_cnt[m][ch] = m_cnt[m][ch] - 1;
                        end
                    end
                    3'd3: m_cnt[m][ch] = 0;
                    3'd4: m_cnt[m][ch] = int'(imm);
                    3'd5: m_lim[m][ch] = int'(imm);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        apply(3'd1, 4'h9, 8'h00, 1'b0);
        apply(3'd0, 4'h9, 8'h00, 1'b0);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL reset_state inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
            n_checks++;
            if ({zero_o[m], atl_o[m]} !== 8'hF0) begin
                n_fail++;
                $display("FAIL reset_flags inst%0d got %h want f0", m, {zero_o[m], atl_o[m]});
            end
        end
    endtask

    task automatic test_inc_basic();
        repeat (3) apply(3'd1, 4'h9, 8'h00, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL inc_basic inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
            n_checks++;
            if ({cnt_o[m], zero_o[m]} !== {32'h0000_0003, 4'b1110}) begin
                n_fail++;
                $display("FAIL inc_basic_const inst%0d got %h/%b want 00000003/1110", m, cnt_o[m], zero_o[m]);
            end
        end
    endtask

    task automatic test_wrap_inc();
        logic [7:0] ch1;
        apply(3'd5, 4'hA, 8'd5, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL setlim_no_count_change inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
        apply(3'd4, 4'hA, 8'd5, 1'b1);
        apply(3'd1, 4'hA, 8'd0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL inc_at_limit inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
            ch1 = cnt_o[m][15:8];
            n_checks++;
            if ({ch1, wrp_o[m]} !== ((m == 0) ? {8'd0, 4'b0010} : {8'd5, 4'b0000})) begin
                n_fail++;
                $display("FAIL inc_at_limit_const inst%0d got ch1=%0d wrap=%b", m, ch1, wrp_o[m]);
            end
        end
        apply(3'd0, 4'hA, 8'd0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (wrp_o[m] !== 4'b0000 || got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL wrap_one_cycle inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_dec_wrap();
        apply(3'd2, 4'hB, 8'd0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL dec_from_zero inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
            n_checks++;
            if ({cnt_o[m][23:16], wrp_o[m][2]} !== ((m == 0) ? 9'h1FF : 9'h000)) begin
                n_fail++;
                $display("FAIL dec_from_zero_const inst%0d got ch2=%h wrap=%b", m, cnt_o[m][23:16], wrp_o[m][2]);
            end
        end
    endtask

    task automatic test_bad_sel();
        logic [3:0] sels [3] = '{4'h0, 4'hD, 4'h8};
        for (int s = 0; s < 3; s++) begin
            apply(3'd1, sels[s], 8'h00, 1'b1);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (err_o[m] !== 1'b1 || got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL bad_sel_%h inst%0d got %h want %h", sels[s], m, got_vec(m), exp_vec(m));
                end
            end
        end
        apply(3'd7, 4'h9, 8'h00, 1'b1);
        apply(3'd0, 4'h0, 8'h00, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (err_o[m] !== 1'b0 || got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL err_one_cycle inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_clrall();
        for (int ch = 0; ch < 4; ch++) apply(3'd4, 4'(9 + ch), 8'(ch * 17 + 3), 1'b1);
        apply(3'd6, 4'h0, 8'h00, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (zero_o[m] !== 4'hF || got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL clrall inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_limit_zero();
        apply(3'd5, 4'hC, 8'd0, 1'b1);
        repeat (2) begin
            apply(3'd1, 4'hC, 8'd0, 1'b1);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL limit_zero_inc inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
                end
            end
        end
        apply(3'd2, 4'hC, 8'd0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (cnt_o[m][31:24] !== 8'd0 || got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL limit_zero_dec inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_back_to_back();
        apply(3'd4, 4'h9, 8'd250, 1'b1);
        for (int k = 0; k < 8; k++) begin
            apply((k % 3 == 2) ? 3'd2 : 3'd1, 4'h9, 8'd0, 1'b1);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL back_to_back step%0d inst%0d got %h want %h", k, m, got_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] sel;
        logic [7:0] imm;
        logic       rn;
        for (int k = 0; k < 400; k++) begin
            op  = 3'($urandom_range(7));
            sel = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(12, 9));
            imm = ($urandom_range(1) == 0) ? 8'($urandom_range(6)) : 8'($urandom);
            rn  = ($urandom_range(60) != 0);
            apply(op, sel, imm, rn);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (got_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL random step%0d op%0d sel%h inst%0d got %h want %h",
                             k, op, sel, m, got_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(3'd5, 4'h9, 8'd0, 1'b1);
        apply(3'd0, 4'h9, 8'd0, 1'b0);
        apply(3'd4, 4'hA, 8'd7, 1'b1);
        repeat (2) apply(3'd1, 4'h9, 8'd0, 1'b1);
        apply(3'd5, 4'hA, 8'd7, 1'b1);
        // Limit == count on ch1 so this inc would wrap; reset must cancel it.
        apply(3'd1, 4'hA, 8'd0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({cnt_o[m], atl_o[m], wrp_o[m], err_o[m]} !== 41'd0 || got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL reset_mid inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
        apply(3'd1, 4'h9, 8'd0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (cnt_o[m][7:0] !== 8'd1 || got_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL first_op_after_reset inst%0d got %h want %h", m, got_vec(m), exp_vec(m));
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        idc_op      = 3'd0;
        instruction = 16'h0000;
        for (int m = 0; m < 2; m++) begin
            m_wrap[m] = 4'b0000;
            m_err[m]  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_cnt[m][k] = 0;
                m_lim[m][k] = 255;
            end
        end
        test_reset();
        test_inc_basic();
        test_wrap_inc();
        test_dec_wrap();
        test_bad_sel();
        test_clrall();
        test_limit_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idc_counter_bank.md
IDC_COUNTER_BANK -- requirements
Module: idc_counter_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent address counters.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the bit width of each counter and limit register.
REQ-003 The block SHALL have parameter BASE_SEL, default 4'b1001, giving the instruction[11:8] code that selects channel 0; channel i is selected by code BASE_SEL+i.
REQ-004 The block SHALL have parameter SAT_MODE, default 0: 0 means counters wrap at the boundaries, 1 means counters saturate.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port idc_op, input, 3 bits: operation code.
REQ-008 The block SHALL have port instruction, input, 16 bits: bits [11:8] select the channel and bits [7:0] carry the immediate value.
REQ-009 The block SHALL have port count_out, output, NUM_CH*WIDTH bits: all counter values, with channel i at bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port at_zero, output, NUM_CH bits: per-channel flag, 1 when the count equals 0.
REQ-011 The block SHALL have port at_limit, output, NUM_CH bits: per-channel flag, 1 when the count equals that channel's limit.
REQ-012 The block SHALL have port wrap_pulse, output, NUM_CH bits: registered one-cycle pulse marking a boundary event.
REQ-013 The block SHALL have port op_err, output, 1 bit: registered one-cycle pulse marking an illegal request.

Function
REQ-014 The block SHALL decode idc_op and instruction[11:8] on the same rising edge at which the operation takes effect, with no pre-latching of instruction.
REQ-015 A select code outside the range BASE_SEL..BASE_SEL+NUM_CH-1 SHALL select no channel.
REQ-016 Operation 000 (hold) SHALL leave all state unchanged.
REQ-017 Operation 001 (inc) SHALL compute count+1 on the selected channel.
REQ-018 Operation 010 (dec) SHALL compute count-1 on the selected channel.
REQ-019 Operation 011 (clr) SHALL set the selected count to 0.
REQ-020 Operation 100 (load) SHALL set the selected count to the immediate, zero-extended or truncated to WIDTH.
REQ-021 Operation 101 (setlim) SHALL set the selected channel's limit register to the immediate, zero-extended or truncated to WIDTH.
REQ-022 Operation 110 (clrall) SHALL set every count to 0 regardless of the select code.
REQ-023 Operation 111 SHALL be reserved and SHALL change no state.
REQ-024 Only the selected channel SHALL change, except under clrall; all other channels SHALL hold.
REQ-025 Inc with count == limit SHALL set count to 0 and pulse wrap_pulse[ch] when SAT_MODE=0, and SHALL hold the count with no pulse when SAT_MODE=1.
REQ-026 Inc with count > limit, reachable by load, SHALL increment modulo 2^WIDTH, with no pulse unless the count equals limit.
REQ-027 Dec with count == 0 SHALL set count to limit and pulse wrap_pulse[ch] when SAT_MODE=0, and SHALL hold 0 with no pulse when SAT_MODE=1.
REQ-028 A load whose immediate exceeds the channel's limit SHALL still be applied.
REQ-029 at_zero and at_limit SHALL be combinational from the current count and limit registers, with no added latency.
REQ-030 count_out SHALL reflect each update one cycle after the operating edge.
REQ-031 wrap_pulse SHALL assert in the cycle after the wrapping edge and SHALL deassert on the next edge unless another wrap occurs.
REQ-032 op_err SHALL pulse for one cycle for an op of 001..101 with an out-of-range select code, or for op 111; the state SHALL be unchanged in that case.
REQ-033 Setting a limit to 0 SHALL be legal: inc then stays at 0 and wraps every cycle in wrap mode, and dec holds at 0 in either mode.
REQ-034 A limit write SHALL NOT alter the count; the new limit SHALL apply from the next operation.
REQ-035 Back-to-back operations on the same channel on consecutive cycles SHALL each apply, using the previously updated value.

Reset
REQ-036 When reset_n=0 on a rising edge, every count SHALL be set to 0.
REQ-037 When reset_n=0 on a rising edge, every limit SHALL be set to all ones (2^WIDTH-1).
REQ-038 When reset_n=0 on a rising edge, wrap_pulse and op_err SHALL be set to 0.
REQ-039 When reset_n=0 on a rising edge, any concurrent idc_op SHALL be ignored.
REQ-040 After reset, at_zero SHALL be all ones and at_limit SHALL be all zeros.
REQ-041 Reset asserted mid-sequence SHALL abort the sequence and cancel any wrap_pulse or op_err due in the next cycle.
REQ-042 The first operation after reset_n returns high SHALL take effect on the following edge.

Verification
REQ-043 Scenario: reset, then 3x inc with instruction[11:8]=1001 -> count_out[7:0]=3, other channels 0, at_zero=4'b1110.
REQ-044 Scenario: setlim ch1 to 5, load ch1 with 5, then inc, SAT_MODE=0 -> ch1=0 and wrap_pulse[1] high for exactly 1 cycle; with SAT_MODE=1 -> ch1=5 and no pulse.
REQ-045 Scenario: dec ch2 from 0 with limit 0xFF -> ch2=0xFF and wrap_pulse[2]=1 (wrap mode); saturate mode -> ch2 stays 0.
REQ-046 Scenario: inc with select code 4'b0000 and with select code 4'b1101 -> op_err pulses 1 cycle each time and no count changes.
REQ-047 Scenario: load all 4 channels with nonzero values, then clrall -> all counts 0 on the next cycle and at_zero=4'hF.
REQ-048 Scenario: inc ch0 for 2 cycles, then reset_n=0 concurrent with an inc -> ch0=0, limits restored to 0xFF, no pulses.
